prince_round_ctrl: RTL and testbench



---
 rtl/prince_round_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_prince_round_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/prince_round_ctrl.sv
// prince_round_ctrl -- iterative PRINCE block cipher, one round per clock.
//
// prince_core: one combinational PRINCE round selected by rc/rc0.
//   rc0=0           : forward round  S, M, add RC[rc] ^ key
//   rc0=1, rc=0     : middle         S, M', S^-1
//   rc0=1, rc=1..5  : backward round add RC[rc] ^ alpha ^ key, M^-1, S^-1
//
// prince_round_ctrl ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           request, accepted when ready=1
//   data_in [63:0]  plaintext, sampled on accept
//   key [127:0]     {k0, k1}, sampled on accept
//   decrypt         (only with PRINCE_DECRYPT_EN) 1 = decrypt, sampled on accept
//   ready           high in IDLE and DONE
//   busy            high in RUN
//   done            one-cycle pulse when data_out updates
//   data_out [63:0] result, held until the next accept
//
// Optional feature macro: PRINCE_DECRYPT_EN (adds the decrypt port).

module prince_core (
   input  logic [63:0] data_in,
   input  logic [63:0] key,
   input  logic [3:0]  rc,
   input  logic        rc0,
   output logic [63:0] data_out
);

   localparam logic [63:0] SBOX     = 64'hBF32AC916780E5D4;
   localparam logic [63:0] SBOX_INV = 64'hB732FD89A6405EC1;
   localparam logic [63:0] ALPHA    = 64'hC0AC29B7C97C50DD;

   // Nibble v of a table sits at bits [4*(15-v) +: 4].
   function automatic logic [3:0] sbox(input logic [3:0] v, input logic inv);
      logic [63:0] t;
      t = inv ? SBOX_INV : SBOX;
      return t[{~v, 2'b00} +: 4];
   endfunction

   function automatic logic [63:0] s_layer(input logic [63:0] x, input logic inv);
      logic [63:0] y;
      y = '0;
      for (int unsigned n = 0; n < 16; n++)
         y[4*n +: 4] = sbox(x[4*n +: 4], inv);
      return y;
   endfunction

   // 16x16 block of M': block (r,c) is identity with a zero at diagonal
   // position (r+c+s)%4. Bit 0 of the math notation is the MSB.
   function automatic logic [15:0] mhat(input logic [15:0] x, input int unsigned s);
      logic [15:0] y;
      y = '0;
      for (int unsigned r = 0; r < 4; r++)
         for (int unsigned i = 0; i < 4; i++)
            for (int unsigned c = 0; c < 4; c++)
               if (((r + c + s) % 4) != i)
                  y[15 - (4*r + i)] = y[15 - (4*r + i)] ^ x[15 - (4*c + i)];
      return y;
   endfunction

   function automatic logic [63:0] mprime(input logic [63:0] x);
      return {mhat(x[63:48], 0), mhat(x[47:32], 1), mhat(x[31:16], 1), mhat(x[15:0], 0)};
   endfunction

   // AES-like ShiftRows on nibbles (nibble 0 = MSB): new[i] = old[5i mod 16].
   function automatic logic [63:0] shift_rows(input logic [63:0] x, input logic inv);
      logic [63:0] y;
      y = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         if (inv) y[63 - 4*((5*i) % 16) -: 4] = x[63 - 4*i -: 4];
         else     y[63 - 4*i -: 4]            = x[63 - 4*((5*i) % 16) -: 4];
      end
      return y;
   endfunction

   function automatic logic [63:0] rc_const(input logic [3:0] idx);
      case (idx)
         4'd1:    return 64'h13198A2E03707344;
         4'd2:    return 64'hA4093822299F31D0;
         4'd3:    return 64'h082EFA98EC4E6C89;
         4'd4:    return 64'h452821E638D01377;
         4'd5:    return 64'hBE5466CF34E90C6C;
         default: return '0;
      endcase
   endfunction

   // RC[11-i] = RC[i] ^ alpha, so backward rounds reuse the RC1..RC5 table.
   always_comb begin
      data_out = '0;
      if (!rc0)
         data_out = shift_rows(mprime(s_layer(data_in, 1'b0)), 1'b0) ^ rc_const(rc) ^ key;
      else if (rc == 4'd0)
         data_out = s_layer(mprime(s_layer(data_in, 1'b0)), 1'b1);
      else
         data_out = s_layer(mprime(shift_rows(data_in ^ key ^ rc_const(rc) ^ ALPHA, 1'b1)), 1'b1);
   end

endmodule

module prince_round_ctrl (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [63:0]  data_in,
   input  logic [127:0] key,
`ifdef PRINCE_DECRYPT_EN
   input  logic         decrypt,
`endif
   output logic         ready,
   output logic         busy,
   output logic         done,
   output logic [63:0]  data_out
);

   localparam logic [63:0] ALPHA = 64'hC0AC29B7C97C50DD;  // also RC11

   typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

   fsm_t        fsm_q, fsm_d;
   logic [3:0]  rnd_q;
   logic [63:0] st_q, k0_q, k1_q, data_out_q;
   logic        done_q;
   logic        accept, last_rnd;
   logic [3:0]  rc;
   logic        rc0;
   logic [63:0] core_out;
   logic        dec_in, dec_q;
   logic [63:0] k0_in, k1_in, pre_k0, post_k0;

   function automatic logic [63:0] k0_prime(input logic [63:0] k);
      return {k[0], k[63:1]} ^ {63'b0, k[63]};
   endfunction

   assign accept   = start && (fsm_q != RUN);
   assign last_rnd = (fsm_q == RUN) && (rnd_q == 4'd11);
   assign ready    = (fsm_q != RUN);
   assign busy     = (fsm_q == RUN);
   assign done     = done_q;
   assign data_out = data_out_q;

`ifdef PRINCE_DECRYPT_EN
   assign dec_in = decrypt;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      dec_q <= 1'b0;
      else if (accept) dec_q <= decrypt;
   end
`else
   assign dec_in = 1'b0;
   assign dec_q  = 1'b0;
`endif

   // Decryption is encryption under {k0', k0, k1^alpha}: the k1 register
   // already holds the adjusted key, so the core and final add need no mux.
   assign k0_in   = key[127:64];
   assign k1_in   = dec_in ? (key[63:0] ^ ALPHA) : key[63:0];
   assign pre_k0  = dec_in ? k0_prime(k0_in) : k0_in;
   assign post_k0 = dec_q ? k0_q : k0_prime(k0_q);

   always_comb begin
      rc  = '0;
      rc0 = 1'b0;
      if (fsm_q == RUN) begin
         if (rnd_q <= 4'd5) begin
            rc = rnd_q;
         end else if (rnd_q == 4'd6) begin
            rc0 = 1'b1;
         end else begin
            rc0 = 1'b1;
            rc  = 4'd12 - rnd_q;
         end
      end
   end

   prince_core u_core (
      .data_in  (st_q),
      .key      (k1_q),
      .rc       (rc),
      .rc0      (rc0),
      .data_out (core_out)
   );

   always_comb begin
      fsm_d = fsm_q;
      case (fsm_q)
         IDLE, DONE: if (start) fsm_d = RUN;
         RUN:        if (rnd_q == 4'd11) fsm_d = DONE;
         default:    fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fsm_q <= IDLE;
      else        fsm_q <= fsm_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rnd_q      <= '0;
         st_q       <= '0;
         k0_q       <= '0;
         k1_q       <= '0;
         data_out_q <= '0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            st_q  <= data_in ^ pre_k0 ^ k1_in;
            k0_q  <= k0_in;
            k1_q  <= k1_in;
            rnd_q <= 4'd1;
         end else if (fsm_q == RUN) begin
            st_q <= core_out;
            if (last_rnd) begin
               data_out_q <= core_out ^ k1_q ^ ALPHA ^ post_k0;
               done_q     <= 1'b1;
               rnd_q      <= '0;
            end else begin
               rnd_q <= rnd_q + 4'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_prince_round_ctrl.sv
module tb_prince_round_ctrl;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [63:0]  data_in;
   logic [127:0] key;
`ifdef PRINCE_DECRYPT_EN
   logic         decrypt;
`endif
   logic         ready, busy, done;
   logic [63:0]  data_out;

   prince_round_ctrl dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .data_in  (data_in),
      .key      (key),
`ifdef PRINCE_DECRYPT_EN
      .decrypt  (decrypt),
`endif
      .ready    (ready),
      .busy     (busy),
      .done     (done),
      .data_out (data_out)
   );

   typedef struct {
      logic [63:0] data;
      logic        chk_data;
      int          due;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          done_cnt = 0;
   logic        prev_done = 1'b0;
   logic [63:0] last_out = '0;

   localparam logic [63:0] PT1 = 64'hFFFFFFFFFFFFFFFF;
   localparam logic [63:0] PT3 = 64'h0123456789ABCDEF;
   localparam logic [127:0] K2 = {64'hFFFFFFFFFFFFFFFF, 64'h0};
   localparam logic [127:0] K3 = {64'h0, 64'hFEDCBA9876543210};
   localparam logic [63:0] CT0 = 64'h818665AA0D02DFDA;
   localparam logic [63:0] CT1 = 64'h604AE6CA03C20ADA;
   localparam logic [63:0] CT2 = 64'h9FB51935FC3DF524;
   localparam logic [63:0] CT3 = 64'hAE25AD3CA8FA9CCF;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, observed no end, expected $finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Scoreboard side: every done pops one expected result.
   always @(negedge clk) begin
      exp_t e;
      if (prev_done) chk("done_one_cycle", {63'b0, done}, 64'd0);
      if (done) begin
         done_cnt++;
         last_out = data_out;
         chk("ready_at_done", {63'b0, ready}, 64'd1);
         chk("busy_at_done", {63'b0, busy}, 64'd0);
         n_checks++;
         assert (exp_q.size() != 0) else begin
            n_errors++;
            $error("FAIL unexpected_done: observed done with %0d pending, expected >=1", exp_q.size());
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (e.chk_data) chk("result", data_out, e.data);
            chk("latency_cycle", 64'(cyc), 64'(e.due));
         end
      end
      prev_done = done;
   end

   task automatic push_exp(input logic [63:0] d, input logic c, input int due);
      exp_t e;
      e.data = d; e.chk_data = c; e.due = due;
      exp_q.push_back(e);
   endtask

   // Accept happens at the edge after this negedge; done is due 12 cycles on.
   task automatic launch(input logic [63:0] pt, input logic [127:0] k,
                         input logic dec, input logic [63:0] exp, input logic c);
      @(negedge clk);
      data_in = pt; key = k; start = 1'b1;
`ifdef PRINCE_DECRYPT_EN
      decrypt = dec;
`else
      if (dec) $display("decrypt request ignored in encrypt-only build");
`endif
      push_exp(exp, c, cyc + 12);
      @(negedge clk);
      start = 1'b0; data_in = ~pt; key = ~k;
   endtask

   task automatic wait_idle();
      int unsigned n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      assert (exp_q.size() == 0) else begin
         n_errors++;
         $error("FAIL timeout: observed %0d results outstanding, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      int t;
      int d0;
      logic [63:0]  pt, ct;
      logic [127:0] k;

      rst_n = 1'b0; start = 1'b0; data_in = '0; key = '0;
`ifdef PRINCE_DECRYPT_EN
      decrypt = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk("rst_ready", {63'b0, ready}, 64'd1);
      chk("rst_busy", {63'b0, busy}, 64'd0);
      chk("rst_done", {63'b0, done}, 64'd0);
      chk("rst_data_out", data_out, 64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_ready", {63'b0, ready}, 64'd1);
      chk("idle_busy", {63'b0, busy}, 64'd0);
      chk("idle_data_out", data_out, 64'd0);

      // Reference vectors
      launch(64'd0, 128'd0, 1'b0, CT0, 1'b1);
      chk("run_busy", {63'b0, busy}, 64'd1);
      chk("run_ready", {63'b0, ready}, 64'd0);
      wait_idle();
      launch(PT1, 128'd0, 1'b0, CT1, 1'b1); wait_idle();
      launch(64'd0, K2, 1'b0, CT2, 1'b1);   wait_idle();
      launch(PT3, K3, 1'b0, CT3, 1'b1);     wait_idle();
      chk("held_data_out", data_out, CT3);

      // Back-to-back with start held; inputs change to the second block
      // while the first runs, so the in-flight start is also ignored.
      @(negedge clk);
      t = cyc;
      data_in = PT1; key = '0; start = 1'b1;
      push_exp(CT1, 1'b1, t + 12);
      @(negedge clk);
      data_in = PT3; key = K3;
      while (cyc < t + 12) @(negedge clk);
      push_exp(CT3, 1'b1, t + 24);
      @(negedge clk);
      start = 1'b0; data_in = '0; key = '1;
      chk("b2b_busy", {63'b0, busy}, 64'd1);
      wait_idle();

      // Start pulse while busy is ignored
      d0 = done_cnt;
      launch(64'd0, K2, 1'b0, CT2, 1'b1);
      repeat (3) @(negedge clk);
      start = 1'b1; data_in = PT1; key = '0;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      repeat (15) @(negedge clk);
      chk("ignored_start_dones", 64'(done_cnt - d0), 64'd1);

      // Asynchronous reset during the middle round (rnd=6)
      launch(PT3, K3, 1'b0, CT3, 1'b1);
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_ready", {63'b0, ready}, 64'd1);
      chk("abort_busy", {63'b0, busy}, 64'd0);
      chk("abort_done", {63'b0, done}, 64'd0);
      chk("abort_data_out", data_out, 64'd0);
      exp_q.delete();
      d0 = done_cnt;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (14) @(negedge clk);
      chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
      launch(PT3, K3, 1'b0, CT3, 1'b1);
      wait_idle();

`ifdef PRINCE_DECRYPT_EN
      launch(CT0, 128'd0, 1'b1, 64'd0, 1'b1);
      wait_idle();
      for (int i = 0; i < 64; i++) begin
         pt = {$urandom(), $urandom()};
         k  = {$urandom(), $urandom(), $urandom(), $urandom()};
         launch(pt, k, 1'b0, 64'd0, 1'b0);
         wait_idle();
         ct = last_out;
         launch(ct, k, 1'b1, pt, 1'b1);
         wait_idle();
      end
`endif

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
